// File: rtl/resilient_pkg.sv
// Shared definitions for the resilient bundled-data sink bridge.
// Contents: FSM state type, default parameter values, FIFO entry layout.
package resilient_pkg;

    localparam int DATA_W_DEF      = 32;
    localparam int DEPTH_DEF       = 4;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int ERRCNT_W_DEF    = 16;

    // Acceptance FSM: IDLE accepts directly, WAIT holds a pending token
    // until the FIFO can take it.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } sink_state_e;

    // One buffered token at the default data width.
    typedef struct packed {
        logic                  err;
        logic [DATA_W_DEF-1:0] data;
    } sink_entry_t;

endpackage

// File: rtl/resilient_sink_fifo.sv
// Show-ahead circular FIFO with an extra pointer bit for full/empty.
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   push_i        : write push_data_i (ignored when full unless popping too)
//   push_data_i   : entry to write
//   pop_i         : consume head (ignored when empty)
//   head_o        : current head entry (show-ahead)
//   level_o       : occupancy 0..DEPTH
//   full_o        : level_o == DEPTH
//   empty_o       : level_o == 0
module resilient_sink_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign level_o   = wr_ptr_q - rd_ptr_q;
    assign full_o    = (level_o == (AW+1)'(DEPTH));
    assign empty_o   = (level_o == {(AW+1){1'b0}});
    assign pop_ok_s  = pop_i & ~empty_o;
    // A pop in the same cycle frees the slot the push needs.
    assign push_ok_s = push_i & (~full_o | pop_ok_s);
    assign head_o    = mem_q[rd_ptr_q[AW-1:0]];

    // Storage and pointer update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= {(AW+1){1'b0}};
            rd_ptr_q <= {(AW+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (push_ok_s) begin
                mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
                wr_ptr_q                <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/resilient_sink_bridge.sv
// Sink for a two-phase bundled-data pipeline stage: synchronises Rreq,
// buffers each token with its timing-error flag, presents tokens on a
// valid/ready interface and counts error-corrected tokens (saturating).
// Ports:
//   clk, rst             : system clock, asynchronous active-low reset
//   req_in / ack_out     : two-phase request / acknowledge with upstream
//   data_in / err_in     : bundled data and error flag (stable until ack)
//   out_valid/out_ready  : downstream handshake; out_data/out_err = head
//   err_clr / err_count  : clear / saturating count of err_in=1 tokens
//   fifo_level           : current FIFO occupancy
module resilient_sink_bridge
    import resilient_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int DEPTH       = DEPTH_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int ERRCNT_W    = ERRCNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_in,
    output logic                    ack_out,
    input  logic [DATA_W-1:0]       data_in,
    input  logic                    err_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_err,
    input  logic                    err_clr,
    output logic [ERRCNT_W-1:0]     err_count,
    output logic [$clog2(DEPTH):0]  fifo_level
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;
    logic                   phase_q;
    sink_state_e            state_q;
    logic                   pending_s;
    logic                   pop_s;
    logic                   push_ok_s;
    logic                   push_s;
    logic                   full_s;
    logic                   empty_s;
    logic [ERRCNT_W-1:0]    err_cnt_q;

    assign req_s     = sync_q[SYNC_STAGES-1];
    // The phase register doubles as the acknowledge: equal phases mean idle.
    assign pending_s = req_s ^ phase_q;
    assign pop_s     = out_valid & out_ready;
    assign push_ok_s = ~full_s | pop_s;
    assign ack_out   = phase_q;
    assign out_valid = ~empty_s;
    assign err_count = err_cnt_q;

    // Request synchroniser chain; data is never synchronised (bundled).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], req_in};
        end
    end

    // Push decode for the current FSM state.
    always_comb begin
        push_s = 1'b0;
        case (state_q)
            IDLE:    push_s = pending_s & push_ok_s;
            WAIT:    push_s = pending_s & push_ok_s;
            default: push_s = 1'b0;
        endcase
    end

    // Acceptance FSM with the phase/acknowledge register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            phase_q <= 1'b0;
        end else begin
            if (push_s) begin
                phase_q <= ~phase_q;
            end
            case (state_q)
                IDLE: begin
                    if (pending_s && !push_ok_s) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (push_s) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Saturating error counter; a clear coinciding with an error push leaves 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt_q <= {ERRCNT_W{1'b0}};
        end else if (err_clr) begin
            err_cnt_q <= (push_s && err_in) ? {{(ERRCNT_W-1){1'b0}}, 1'b1}
                                            : {ERRCNT_W{1'b0}};
        end else if (push_s && err_in && (err_cnt_q != {ERRCNT_W{1'b1}})) begin
            err_cnt_q <= err_cnt_q + {{(ERRCNT_W-1){1'b0}}, 1'b1};
        end
    end

    resilient_sink_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_s),
        .push_data_i ({err_in, data_in}),
        .pop_i       (pop_s),
        .head_o      ({out_err, out_data}),
        .level_o     (fifo_level),
        .full_o      (full_s),
        .empty_o     (empty_s)
    );

endmodule

// File: tb/tb_resilient_sink_bridge.sv
// Self-checking bench for resilient_sink_bridge; the bench plays the
// upstream two-phase stage and the downstream consumer.
module tb_resilient_sink_bridge;

    localparam int CNT_MAX = (1 << 4) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_in = 1'b0;
    logic        ack_out;
    logic [31:0] data_in = 32'h0;
    logic        err_in = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_err;
    logic        err_clr = 1'b0;
    logic [3:0]  err_count;
    logic [2:0]  fifo_level;

    int checks = 0;
    int failures = 0;
    int model_cnt = 0;
    int ack_toggles = 0;
    logic ack_prev = 1'b0;
    logic [32:0] exp_q[$];
    logic [32:0] got_q[$];

    resilient_sink_bridge #(
        .DATA_W(32), .DEPTH(4), .SYNC_STAGES(2), .ERRCNT_W(4)
    ) dut (
        .clk(clk), .rst(rst), .req_in(req_in), .ack_out(ack_out),
        .data_in(data_in), .err_in(err_in), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
        .err_clr(err_clr), .err_count(err_count), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    // Consumer log: inputs change just after posedge, so a negedge sample
    // predicts the pop at the next posedge.
    always @(negedge clk) begin
        if (rst) begin
            if (out_valid && out_ready) got_q.push_back({out_err, out_data});
            if (ack_out !== ack_prev) ack_toggles++;
        end
        ack_prev = ack_out;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Upstream: one token, wait (bounded) for the acknowledge.
    task automatic send(input logic [31:0] d, input logic e, output int lat);
        data_in = d;
        err_in  = e;
        req_in  = ~req_in;
        lat     = 0;
        while (ack_out !== req_in && lat < 50) begin
            tick();
            lat++;
        end
        if (ack_out !== req_in) begin
            lat = -1;
        end else begin
            exp_q.push_back({e, d});
            if (e) model_cnt = (model_cnt < CNT_MAX) ? model_cnt + 1 : CNT_MAX;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) tick();
        checks++;
        if ({ack_out, out_valid, out_data, out_err, err_count, fifo_level} !== 41'h0) begin
            failures++;
            $display("FAIL reset_outputs: got ack=%0b valid=%0b data=%h err=%0b cnt=%0d lvl=%0d want all 0",
                     ack_out, out_valid, out_data, out_err, err_count, fifo_level);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int lat;
        exp_q.delete(); got_q.delete();
        out_ready = 1'b0;
        send(32'hDEADBEEF, 1'b0, lat);
        checks++;
        if (lat !== 3) begin failures++; $display("FAIL single_latency: got %0d want 3", lat); end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL single_head: got valid=%0b data=%h want valid=1 data=deadbeef", out_valid, out_data);
        end
        checks++;
        if (err_count !== 4'd0) begin failures++; $display("FAIL single_errcnt: got %0d want 0", err_count); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        checks++;
        if (got_q.size() != 1 || got_q[0] !== exp_q[0] || fifo_level !== 3'd0) begin
            failures++;
            $display("FAIL single_pop: got n=%0d lvl=%0d want n=1 lvl=0", got_q.size(), fifo_level);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        exp_q.delete(); got_q.delete();
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            send(i, 1'b0, lat);
            checks++;
            if (lat !== 3) begin failures++; $display("FAIL bp_latency: token %0d got %0d want 3", i, lat); end
        end
        checks++;
        if (fifo_level !== 3'd4) begin failures++; $display("FAIL bp_full_level: got %0d want 4", fifo_level); end
        data_in = 32'd5; err_in = 1'b0; req_in = ~req_in;
        repeat (6) tick();
        checks++;
        if (ack_out === req_in || fifo_level !== 3'd4) begin
            failures++;
            $display("FAIL bp_hold: got ack=%0b lvl=%0d want ack=%0b lvl=4", ack_out, fifo_level, ~req_in);
        end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        exp_q.push_back({1'b0, 32'd5});
        checks++;
        if (ack_out !== req_in || fifo_level !== 3'd4) begin
            failures++;
            $display("FAIL bp_swap: got ack=%0b lvl=%0d want ack=%0b lvl=4", ack_out, fifo_level, req_in);
        end
        out_ready = 1'b1; repeat (4) tick(); out_ready = 1'b0;
        checks++;
        if (got_q.size() != 5 || fifo_level !== 3'd0) begin
            failures++;
            $display("FAIL bp_drain_count: got n=%0d lvl=%0d want n=5 lvl=0", got_q.size(), fifo_level);
        end
        for (int i = 0; i < 5 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL bp_order[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_errors();
        int lat;
        logic [4:0] pat;
        exp_q.delete(); got_q.delete();
        out_ready = 1'b1;
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        model_cnt = 0;
        checks++;
        if (err_count !== 4'd0) begin failures++; $display("FAIL err_clear: got %0d want 0", err_count); end
        pat = 5'b10101;
        pat = (pat << 2) | (pat >> 3);   // still three ones
        if ($urandom_range(0, 1) == 1) pat = {pat[0], pat[4:1]};
        for (int i = 0; i < 5; i++) begin
            send($urandom, pat[i], lat);
        end
        repeat (2) tick();
        checks++;
        if (err_count !== 4'(model_cnt)) begin
            failures++;
            $display("FAIL err_count: got %0d want %0d", err_count, model_cnt);
        end
        // clear in the same edge as an err_in=1 push
        data_in = $urandom; err_in = 1'b1; req_in = ~req_in;
        tick(); tick();
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        exp_q.push_back({1'b1, data_in});
        model_cnt = 1;
        checks++;
        if (ack_out !== req_in || err_count !== 4'(model_cnt)) begin
            failures++;
            $display("FAIL err_clr_push: got ack=%0b cnt=%0d want ack=%0b cnt=1", ack_out, err_count, req_in);
        end
        repeat (2) tick();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL err_stream_len: got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL err_head[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_saturation();
        int lat;
        exp_q.delete(); got_q.delete();
        out_ready = 1'b1;
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        model_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            send($urandom, 1'b1, lat);
            if (i == 14) begin
                checks++;
                if (err_count !== 4'(model_cnt)) begin
                    failures++;
                    $display("FAIL sat_at15: got %0d want %0d", err_count, model_cnt);
                end
            end
        end
        repeat (2) tick();
        checks++;
        if (err_count !== 4'(model_cnt) || got_q.size() != 20) begin
            failures++;
            $display("FAIL sat_final: got cnt=%0d n=%0d want cnt=%0d n=20", err_count, got_q.size(), model_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        exp_q.delete(); got_q.delete();
        out_ready = 1'b0;
        send(32'hA1, 1'b0, lat);
        send(32'hB2, 1'b1, lat);
        data_in = 32'hC3; err_in = 1'b0; req_in = ~req_in;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || ack_out !== 1'b0 || fifo_level !== 3'd0 || err_count !== 4'd0) begin
            failures++;
            $display("FAIL mid_reset: got valid=%0b ack=%0b lvl=%0d cnt=%0d want 0 0 0 0",
                     out_valid, ack_out, fifo_level, err_count);
        end
        req_in = 1'b0;
        model_cnt = 0;
        exp_q.delete(); got_q.delete();
        tick(); tick();
        rst = 1'b1;
        tick();
        send(32'h600DF00D, 1'b0, lat);
        checks++;
        if (lat !== 3 || out_valid !== 1'b1 || out_data !== 32'h600DF00D || fifo_level !== 3'd1) begin
            failures++;
            $display("FAIL post_reset_token: got lat=%0d valid=%0b data=%h lvl=%0d want 3 1 600df00d 1",
                     lat, out_valid, out_data, fifo_level);
        end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int lat;
        int bad_lat;
        int t0;
        exp_q.delete(); got_q.delete();
        out_ready = 1'b1;
        bad_lat = 0;
        t0 = ack_toggles;
        for (int i = 0; i < 100; i++) begin
            send($urandom, 1'($urandom_range(0, 1)), lat);
            if (lat !== 3) bad_lat++;
        end
        repeat (3) tick();
        checks++;
        if (bad_lat != 0) begin failures++; $display("FAIL stream_latency: got %0d slow tokens want 0", bad_lat); end
        checks++;
        if (ack_toggles - t0 != 100) begin
            failures++;
            $display("FAIL stream_acks: got %0d want 100", ack_toggles - t0);
        end
        checks++;
        if (got_q.size() != 100) begin
            failures++;
            $display("FAIL stream_len: got %0d want 100", got_q.size());
        end
        for (int i = 0; i < 100 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL stream_token[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (err_count !== 4'(model_cnt)) begin
            failures++;
            $display("FAIL stream_errcnt: got %0d want %0d", err_count, model_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_errors();
        test_saturation();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
